// File: rtl/ram_ctrl_pkg.sv
// Shared command and FSM state encodings for the SPI-to-RAM port controller.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_RESP = 3'd5
    } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram_port_ctrl_if.sv
// Single-port RAM request/response bundle between the controller (master) and the RAM (slave).
interface ram_port_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 8
) ();

    logic [ADDR_SIZE-1:0] ram_addr;
    logic [ADDR_SIZE-1:0] ram_din;
    logic                 ram_rx_en;
    logic                 ram_tx_en;
    logic [ADDR_SIZE-1:0] ram_dout;
    logic                 ram_rx_valid;
    logic                 ram_tx_valid;

    modport master (
        output ram_addr,
        output ram_din,
        output ram_rx_en,
        output ram_tx_en,
        input  ram_dout,
        input  ram_rx_valid,
        input  ram_tx_valid
    );

    modport slave (
        input  ram_addr,
        input  ram_din,
        input  ram_rx_en,
        input  ram_tx_en,
        output ram_dout,
        output ram_rx_valid,
        output ram_tx_valid
    );

endinterface : ram_port_ctrl_if

// File: rtl/ram_port_ctrl.sv
// Decodes SPI command words into single-cycle RAM write/read requests, waits for the
// RAM response with a timeout, and returns read data to SPI. All outputs are registered.
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned TMO_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout,
    ram_port_ctrl_if.master      ram
);

    localparam int unsigned          CNT_W     = $clog2(TMO_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TMO_CYCLES - 1);
    localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    // Address increment that wraps to 0 after the last RAM location.
    function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_SIZE-1:0] ram_din_q, ram_din_d;
    logic                 ram_rx_en_q, ram_rx_en_d;
    logic                 ram_tx_en_q, ram_tx_en_d;

    cmd_e                 cmd_c;
    logic [ADDR_SIZE-1:0] payload_c;

    assign cmd_c     = cmd_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload_c = rx_data[ADDR_SIZE-1:0];

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_rx_en_q <= 1'b0;
            ram_tx_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_rx_en_q <= ram_rx_en_d;
            ram_tx_en_q <= ram_tx_en_d;
        end
    end

    // Next-state and next-output logic; pulses default low, data/address default hold.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_rx_en_d = 1'b0;
        ram_tx_en_d = 1'b0;

        // Any command arriving outside IDLE is dropped, including on the return-to-IDLE edge.
        if (rx_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (cmd_c)
                        CMD_WR_ADDR: wr_addr_d = payload_c;
                        CMD_RD_ADDR: rd_addr_d = payload_c;
                        CMD_WR_DATA: begin
                            state_d     = WR_REQ;
                            ram_rx_en_d = 1'b1;
                            ram_addr_d  = wr_addr_q;
                            ram_din_d   = payload_c;
                        end
                        CMD_RD_DATA: begin
                            state_d     = RD_REQ;
                            ram_tx_en_d = 1'b1;
                            ram_addr_d  = rd_addr_q;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR_REQ: begin
                state_d = WR_WAIT;
                cnt_d   = '0;
            end
            WR_WAIT: begin
                if (ram.ram_rx_valid) begin
                    state_d   = IDLE;
                    wr_addr_d = addr_inc(wr_addr_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                // Response is registered straight into tx_data/tx_valid, so RD_RESP is never needed.
                if (ram.ram_tx_valid) begin
                    state_d    = IDLE;
                    tx_data_d  = ram.ram_dout;
                    tx_valid_d = 1'b1;
                    rd_addr_d  = addr_inc(rd_addr_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_din   = ram_din_q;
    assign ram.ram_rx_en = ram_rx_en_q;
    assign ram.ram_tx_en = ram_tx_en_q;

endmodule : ram_port_ctrl
